// File: rtl/page_match_pkg.sv
// rtl/page_match_pkg.sv - shared geometry, types and sweep states for the page loader and finder
package page_match_pkg;

   localparam int P_SIZE = 12;
   localparam int NOB    = 3;
   localparam int PPB    = 8;
   localparam int NOP    = NOB * PPB;
   localparam int SETTLE = 3;

   localparam logic [P_SIZE-1:0] ERASE_VAL = 12'hFFF;

   typedef logic [4:0] pidx_t;
   typedef logic [2:0] bidx_t;
   typedef logic [1:0] settle_cnt_t;

   localparam settle_cnt_t SETTLE_LAST = settle_cnt_t'(SETTLE - 1);
   localparam bidx_t       BIDX_LAST   = bidx_t'(NOB - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_PUT,
      ST_NEXT,
      ST_DONE
   } seq_state_e;

endpackage

// File: rtl/loader_seq_fsm.sv
// rtl/loader_seq_fsm.sv - block sweep sequencer: holds b_idx for the finder to settle, then strobes put
module loader_seq_fsm
   import page_match_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush_req_i,
   output logic       idle_o,
   output logic [2:0] b_idx_o,
   output logic       put_strobe_o,
   output logic       flush_done_o,
   output logic       flush_busy_o
);

   seq_state_e  state_q, state_d;
   settle_cnt_t cnt_q, cnt_d;
   bidx_t       bidx_q, bidx_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bidx_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bidx_d       = bidx_q;
      idle_o       = 1'b0;
      put_strobe_o = 1'b0;
      flush_done_o = 1'b0;
      flush_busy_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            idle_o = 1'b1;
            if (flush_req_i) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
               bidx_d  = '0;
            end
         end
         ST_SETTLE: begin
            flush_busy_o = 1'b1;
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_PUT;
            end else begin
               cnt_d = cnt_q + settle_cnt_t'(1);
            end
         end
         ST_PUT: begin
            flush_busy_o = 1'b1;
            put_strobe_o = 1'b1;
            state_d      = ST_NEXT;
         end
         ST_NEXT: begin
            // b_idx only moves here, so it is frozen across SETTLE and PUT
            flush_busy_o = 1'b1;
            if (bidx_q == BIDX_LAST) begin
               state_d = ST_DONE;
            end else begin
               bidx_d  = bidx_q + bidx_t'(1);
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         ST_DONE: begin
            flush_done_o = 1'b1;
            bidx_d       = '0;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign b_idx_o = bidx_q;

endmodule

// File: rtl/page_array_loader.sv
// rtl/page_array_loader.sv - page write path and packed image, sequences the finder on flush
// Define LOADER_CLEAR_ON_FLUSH_EN to empty the loader when a sweep completes.
module page_array_loader
   import page_match_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [4:0]   wr_pidx,
   input  logic [11:0]  wr_data,
   output logic         wr_err,
   input  logic         flush_req,
   output logic         flush_busy,
   output logic         flush_done,
   output logic [287:0] a_out,
   output logic [2:0]   b_idx_out,
   output logic         put_strobe,
   output logic [23:0]  page_vld,
   output logic [4:0]   wr_count
);

   localparam logic [NOP*P_SIZE-1:0] IMG_ERASED = {NOP{ERASE_VAL}};

   logic [NOP*P_SIZE-1:0] img_q, img_d;
   logic [NOP-1:0]        vld_q, vld_d;
   pidx_t                 cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  seq_idle;
   logic                  wr_fire;

   loader_seq_fsm u_seq (
      .clk          (clk),
      .rst          (rst),
      .flush_req_i  (flush_req),
      .idle_o       (seq_idle),
      .b_idx_o      (b_idx_out),
      .put_strobe_o (put_strobe),
      .flush_done_o (flush_done),
      .flush_busy_o (flush_busy)
   );

   // Writes are taken only while idle, so the image cannot shift under a sweep
   assign wr_ready = seq_idle;
   assign wr_fire  = wr_valid && wr_ready;

   always_comb begin
      img_d = img_q;
      vld_d = vld_q;
      cnt_d = cnt_q;
      err_d = 1'b0;
      if (wr_fire) begin
         if (wr_pidx < pidx_t'(NOP)) begin
            img_d[wr_pidx*P_SIZE +: P_SIZE] = wr_data;
            if (!vld_q[wr_pidx]) begin
               vld_d[wr_pidx] = 1'b1;
               if (cnt_q < pidx_t'(NOP)) begin
                  cnt_d = cnt_q + pidx_t'(1);
               end
            end
         end else begin
            err_d = 1'b1;
         end
      end
`ifdef LOADER_CLEAR_ON_FLUSH_EN
      if (flush_done) begin
         img_d = IMG_ERASED;
         vld_d = '0;
         cnt_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         img_q <= IMG_ERASED;
         vld_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         img_q <= img_d;
         vld_q <= vld_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign a_out    = img_q;
   assign page_vld = vld_q;
   assign wr_count = cnt_q;
   assign wr_err   = err_q;

endmodule
